// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared screen geometry, pixel format and blitter state type
package sprite_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIX_W    = 5;
  localparam int FB_AW    = 19;
  localparam logic [PIX_W-1:0] TRANSPARENT_IDX = 5'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// rtl/sprite_blitter_if.sv - draw request, sprite ROM and frame-buffer signals
// SPRITE_BLIT_HFLIP_EN adds the hflip request bit.
interface sprite_blitter_if;
  import sprite_pkg::*;

  logic             start;
  logic [9:0]       pos_x;
  logic [9:0]       pos_y;
`ifdef SPRITE_BLIT_HFLIP_EN
  logic             hflip;
`endif
  logic             busy;
  logic             done;
  logic [FB_AW-1:0] rom_addr;
  logic [PIX_W-1:0] rom_data;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [PIX_W-1:0] fb_data;

`ifdef SPRITE_BLIT_HFLIP_EN
  modport master (input start, pos_x, pos_y, hflip, rom_data,
                  output busy, done, rom_addr, fb_we, fb_addr, fb_data);
  modport slave  (output start, pos_x, pos_y, hflip, rom_data,
                  input busy, done, rom_addr, fb_we, fb_addr, fb_data);
`else
  modport master (input start, pos_x, pos_y, rom_data,
                  output busy, done, rom_addr, fb_we, fb_addr, fb_data);
  modport slave  (output start, pos_x, pos_y, rom_data,
                  input busy, done, rom_addr, fb_we, fb_addr, fb_data);
`endif
endinterface

// File: rtl/sprite_blit_counter.sv
// rtl/sprite_blit_counter.sv - row/col walk, ROM address, fb row base, last-pixel flag
// SPRITE_BLIT_HFLIP_EN adds mirrored ROM addressing.
module sprite_blit_counter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 28,
  parameter int SPRITE_H = 50,
  localparam int COL_W  = $clog2(SPRITE_W),
  localparam int ROW_W  = $clog2(SPRITE_H),
  localparam int ADDR_W = $clog2(SPRITE_W * SPRITE_H + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [FB_AW:0]   i_fbase_init,
`ifdef SPRITE_BLIT_HFLIP_EN
  input  logic             i_hflip,
`endif
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic [FB_AW-1:0] o_rom_addr,
  output logic [FB_AW:0]   o_fbase,
  output logic             o_last
);
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic [FB_AW:0]    r_fbase;
  logic              w_col_wrap;
`ifdef SPRITE_BLIT_HFLIP_EN
  logic [ADDR_W-1:0] r_rbase;
`endif

  assign w_col_wrap = (r_col == COL_W'(SPRITE_W - 1));

  // Forward address and both row bases advance by addition only.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_fbase <= i_rst ? '0 : i_fbase_init;
`ifdef SPRITE_BLIT_HFLIP_EN
      r_rbase <= '0;
`endif
    end else if (i_advance) begin
      r_addr <= r_addr + 1'b1;
      if (w_col_wrap) begin
        r_col   <= '0;
        r_row   <= r_row + 1'b1;
        r_fbase <= r_fbase + (FB_AW+1)'(SCREEN_W);
`ifdef SPRITE_BLIT_HFLIP_EN
        r_rbase <= r_rbase + ADDR_W'(SPRITE_W);
`endif
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col   = r_col;
  assign o_row   = r_row;
  assign o_fbase = r_fbase;
  assign o_last  = w_col_wrap && (r_row == ROW_W'(SPRITE_H - 1));
`ifdef SPRITE_BLIT_HFLIP_EN
  assign o_rom_addr = i_hflip ?
      FB_AW'(r_rbase + ADDR_W'(SPRITE_W - 1) - ADDR_W'(r_col)) : FB_AW'(r_addr);
`else
  assign o_rom_addr = FB_AW'(r_addr);
`endif
endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - copies a sprite ROM into the frame buffer at (pos_x,pos_y)
// SPRITE_BLIT_HFLIP_EN enables horizontal mirroring via the hflip request bit.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 28,
  parameter int SPRITE_H = 50
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sprite_blitter_if.master   blit
);
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  blit_state_t      r_state, w_next;
  logic [9:0]       r_pos_x, r_pos_y;
  logic [10:0]      r_px, r_py;
  logic [FB_AW:0]   r_pbase;
  logic             r_pvalid;
  logic             w_accept;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [FB_AW-1:0] w_rom_addr;
  logic [FB_AW:0]   w_fbase;
  logic             w_last;
  logic [10:0]      w_x, w_y;
`ifdef SPRITE_BLIT_HFLIP_EN
  logic             r_hflip;
`endif

  assign w_accept = (r_state == IDLE) && blit.start;

  sprite_blit_counter #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_counter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_accept),
    .i_advance    (r_state == FETCH),
    .i_fbase_init ((FB_AW+1)'(blit.pos_y) * (FB_AW+1)'(SCREEN_W)),
`ifdef SPRITE_BLIT_HFLIP_EN
    .i_hflip      (r_hflip),
`endif
    .o_col        (w_col),
    .o_row        (w_row),
    .o_rom_addr   (w_rom_addr),
    .o_fbase      (w_fbase),
    .o_last       (w_last)
  );

  // 11-bit sums so targets past the right/bottom edge compare as off-screen.
  assign w_x = {1'b0, r_pos_x} + 11'(w_col);
  assign w_y = {1'b0, r_pos_y} + 11'(w_row);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (blit.start) w_next = FETCH;
      FETCH:   if (w_last) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_pos_x  <= '0;
      r_pos_y  <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_pbase  <= '0;
      r_pvalid <= 1'b0;
`ifdef SPRITE_BLIT_HFLIP_EN
      r_hflip  <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_pvalid <= (r_state == FETCH);
      if (w_accept) begin
        r_pos_x <= blit.pos_x;
        r_pos_y <= blit.pos_y;
`ifdef SPRITE_BLIT_HFLIP_EN
        r_hflip <= blit.hflip;
`endif
      end
      // Target of the address issued this cycle, consumed when its data returns.
      if (r_state == FETCH) begin
        r_px    <= w_x;
        r_py    <= w_y;
        r_pbase <= w_fbase;
      end
    end
  end

  assign blit.busy     = (r_state == FETCH) || (r_state == DRAIN);
  assign blit.done     = (r_state == DONE);
  assign blit.rom_addr = (r_state == FETCH) ? w_rom_addr : '0;
  assign blit.fb_we    = r_pvalid && (blit.rom_data != TRANSPARENT_IDX) &&
                         (r_px < 11'(SCREEN_W)) && (r_py < 11'(SCREEN_H));
  assign blit.fb_data  = r_pvalid ? blit.rom_data : '0;
  assign blit.fb_addr  = FB_AW'(r_pbase + (FB_AW+1)'(r_px));
endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed bench for sprite_blitter (SPRITE_BLIT_HFLIP_EN adds a mirror case)
module tb_sprite_blitter;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_blitter_if bif();
  sprite_blitter dut (.i_clk(clk), .i_rst(rst), .blit(bif));

  int total = 0;
  int bad   = 0;
  int mode  = 0;

  int n_wr, first_addr, last_addr, first_cyc, last_cyc;
  int n_done, done_cyc, n_busy_done, n_bad_data, n_out_rect, n_oob, n_addr0;
  int n_1f, addr_1f, rom2, rom1400, busy1403, busy1404;

  function automatic logic [4:0] rom_val(input logic [18:0] a);
    case (mode)
      0:       return 5'h03;
      1:       return a[0] ? 5'h07 : 5'h00;
      2:       return 5'h01;
      default: return (a == 19'd0) ? 5'h1F : 5'h02;
    endcase
  endfunction

  function automatic logic [4:0] exp_data(input int a);
    case (mode)
      0:       return 5'h03;
      1:       return 5'h07;
      2:       return 5'h01;
      default: return (a == 27) ? 5'h1F : 5'h02;
    endcase
  endfunction

  always @(posedge clk) bif.rom_data <= rom_val(bif.rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_wr = 0; first_addr = -1; last_addr = -1; first_cyc = -1; last_cyc = -1;
    n_done = 0; done_cyc = -1; n_busy_done = 0; n_bad_data = 0; n_out_rect = 0;
    n_oob = 0; n_addr0 = 0; n_1f = 0; addr_1f = -1; rom2 = -1; rom1400 = -1;
    busy1403 = -1; busy1404 = -1;
  endtask

  task automatic sample(input int c, input int x, input int y);
    int a, ax, ay;
    if (bif.fb_we) begin
      a = int'(bif.fb_addr);
      if (n_wr == 0) begin first_addr = a; first_cyc = c; end
      last_addr = a; last_cyc = c; n_wr++;
      if (bif.fb_data != exp_data(a)) n_bad_data++;
      if (bif.fb_data == 5'h1F) begin n_1f++; addr_1f = a; end
      ax = a % SCREEN_W; ay = a / SCREEN_W;
      if (ax < x || ax > x + 27 || ay < y || ay > y + 49) n_out_rect++;
      if (a >= SCREEN_W * SCREEN_H) n_oob++;
      if (a == 0) n_addr0++;
    end
    if (bif.done) begin n_done++; done_cyc = c; end
    if (bif.busy && bif.done) n_busy_done++;
    if (c == 2) rom2 = int'(bif.rom_addr);
    if (c == 1400) rom1400 = int'(bif.rom_addr);
    if (c == 1403) busy1403 = int'(bif.busy);
    if (c == 1404) busy1404 = int'(bif.busy);
  endtask

  // Start sampled at edge 0; cycle c is sampled on the negedge after edge c-1.
  task automatic run_draw(input int x, input int y, input bit hold, input int ncyc);
    clear_stats();
    @(negedge clk);
    bif.pos_x = 10'(x); bif.pos_y = 10'(y); bif.start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      sample(c, x, y);
      if (!hold) bif.start = 1'b0;
      else if (c == 3) begin bif.pos_x = 10'd300; bif.pos_y = 10'd300; end
    end
    bif.start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bif.start = 1'b0; bif.pos_x = '0; bif.pos_y = '0;
`ifdef SPRITE_BLIT_HFLIP_EN
    bif.hflip = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_done", 32'(bif.done), 0);
    chk("rst_fb_we", 32'(bif.fb_we), 0);
    chk("rst_rom_addr", 32'(bif.rom_addr), 0);
    chk("rst_fb_addr", 32'(bif.fb_addr), 0);
    chk("rst_fb_data", 32'(bif.fb_data), 0);
    rst = 1'b0;

    mode = 0;
    run_draw(100, 200, 1'b0, 1403);
    chk("pos_writes", n_wr, 1400);
    chk("pos_first_addr", first_addr, 128100);
    chk("pos_last_addr", last_addr, 159487);
    chk("pos_first_cyc", first_cyc, 2);
    chk("pos_last_cyc", last_cyc, 1401);
    chk("pos_bad_data", n_bad_data, 0);
    chk("pos_out_rect", n_out_rect, 0);
    chk("pos_done_cyc", done_cyc, 1402);
    chk("pos_done_cnt", n_done, 1);
    chk("pos_rom_c2", rom2, 1);
    chk("pos_rom_c1400", rom1400, 1399);

    mode = 1;
    run_draw(0, 0, 1'b0, 1403);
    chk("tr_writes", n_wr, 700);
    chk("tr_first_addr", first_addr, 1);
    chk("tr_addr0", n_addr0, 0);
    chk("tr_bad_data", n_bad_data, 0);

    mode = 2;
    run_draw(620, 470, 1'b0, 1403);
    chk("clip_writes", n_wr, 200);
    chk("clip_oob", n_oob, 0);
    chk("clip_out_rect", n_out_rect, 0);
    chk("clip_first_addr", first_addr, 301420);
    chk("clip_last_addr", last_addr, 307199);
    chk("clip_done_cyc", done_cyc, 1402);

    mode = 0;
    run_draw(10, 10, 1'b1, 1404);
    chk("hs_writes", n_wr, 1400);
    chk("hs_first_addr", first_addr, 6410);
    chk("hs_out_rect", n_out_rect, 0);
    chk("hs_done_cyc", done_cyc, 1402);
    chk("hs_done_cnt", n_done, 1);
    chk("hs_busy_done", n_busy_done, 0);
    chk("hs_busy_c1403", busy1403, 0);
    chk("hs_busy_c1404", busy1404, 1);
    do_reset();

    clear_stats();
    @(negedge clk);
    bif.pos_x = '0; bif.pos_y = '0; bif.start = 1'b1;
    for (int c = 1; c <= 530; c++) begin
      @(negedge clk);
      bif.start = 1'b0;
      if (c == 500) begin
        chk("rm_busy_before", 32'(bif.busy), 1);
        rst = 1'b1;
      end
      if (c == 501) begin
        chk("rm_fb_we_after", 32'(bif.fb_we), 0);
        chk("rm_busy_after", 32'(bif.busy), 0);
        rst = 1'b0;
      end
      if (c > 501) begin
        if (bif.fb_we) n_wr++;
        if (bif.busy) n_busy_done++;
      end
    end
    chk("rm_no_writes", n_wr, 0);
    chk("rm_no_busy", n_busy_done, 0);
    run_draw(0, 0, 1'b0, 1403);
    chk("rm_re_writes", n_wr, 1400);
    chk("rm_re_first", first_addr, 0);
    chk("rm_re_last", last_addr, 31387);
    chk("rm_re_done_cyc", done_cyc, 1402);

`ifdef SPRITE_BLIT_HFLIP_EN
    mode = 3;
    bif.hflip = 1'b1;
    run_draw(0, 0, 1'b0, 1403);
    bif.hflip = 1'b0;
    chk("hf_writes", n_wr, 1400);
    chk("hf_1f_cnt", n_1f, 1);
    chk("hf_1f_addr", addr_1f, 27);
    chk("hf_bad_data", n_bad_data, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Reader and consumer side of the sprite ROM interface: walks a sprite ROM (e.g. the police sprite), pixel by pixel, and copies it into the frame-buffer write port at a requested screen position.
- Issues ROM read addresses and absorbs the ROM's registered one-cycle read latency.
- Drops transparent pixels and pixels that fall off-screen.
- Sits between game logic (which requests draws via start/busy/done) and the frame-buffer RAM.

Parameters:
- SPRITE_W, 28, sprite width in pixels.
- SPRITE_H, 50, sprite height in pixels (SPRITE_W*SPRITE_H = ROM depth, 1400).
- SCREEN_W, 640, frame-buffer width.
- SCREEN_H, 480, frame-buffer height.
- TRANSPARENT_IDX, 5'h00, palette index that is never written.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  draw request, sampled only in IDLE.
- pos_x  in  10  sprite top-left X, latched on accepted start.
- pos_y  in  10  sprite top-left Y, latched on accepted start.
- busy  out  1  high in FETCH and DRAIN.
- done  out  1  one-cycle pulse when a draw completes.
- rom_addr  out  19  sprite ROM read address.
- rom_data  in  5  ROM palette index; valid one cycle after rom_addr.
- fb_we  out  1  frame-buffer write enable.
- fb_addr  out  19  frame-buffer address, y*SCREEN_W+x.
- fb_data  out  5  palette index to write.

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0; all counters 0.
- IDLE:
  - start=1 at an edge latches pos_x/pos_y, clears row/col, and moves to FETCH.
  - start is ignored in every other state.
- FETCH:
  - Lasts exactly SPRITE_W*SPRITE_H cycles.
  - Each cycle, rom_addr = row*SPRITE_W + col.
  - Address is generated by an incrementing counter; no multiplier.
  - col increments every cycle; at col=SPRITE_W-1, col wraps to 0 and row increments.
  - After the last pixel (row=SPRITE_H-1, col=SPRITE_W-1) is issued, go to DRAIN.
- Pipeline:
  - A 1-stage register holds target (x,y) and a valid bit for the address issued last cycle.
  - In the cycle after issue: fb_data = rom_data, fb_addr = row base + x.
  - Row base is maintained incrementally: +SCREEN_W per row.
- Write qualification: fb_we = valid AND rom_data != TRANSPARENT_IDX AND x < SCREEN_W AND y < SCREEN_H.
  - Sums use 11-bit width, so pos_x + col never wraps.
- DRAIN: one cycle to complete the final write, then go to DONE.
- DONE: done=1, busy=0, fb_we=0 for one cycle, then return to IDLE.
  - A start asserted during DONE is ignored; the next start is accepted from IDLE.
- Timing, with start sampled at edge 0:
  - FETCH occupies cycles 1..1400.
  - Writes are possible in cycles 2..1401.
  - done is high in cycle 1402.
- Reset mid-operation: next cycle state=IDLE, fb_we=0, busy=0, pipeline valid cleared, no further writes.
- pos_x/pos_y changing during busy has no effect.

Optional Feature:
- Macro: SPRITE_BLIT_HFLIP_EN.
- Defined:
  - Adds input hflip (1 bit), latched with start.
  - When latched as 1: rom_addr = row*SPRITE_W + (SPRITE_W-1-col), while fb x remains pos_x+col, producing a mirrored sprite.
  - Timing and clipping are unchanged.
- Undefined: no hflip port; read order is always forward.

Decomposition:
- Shared package sprite_pkg holds:
  - SCREEN_W, SCREEN_H, PIX_W=5, FB_AW=19, TRANSPARENT_IDX.
  - State enum blit_state_t {IDLE, FETCH, DRAIN, DONE}.
- One sub-module is natural: sprite_blit_counter.
  - Generates row/col, ROM address, fb row base and the last-pixel flag.
  - Top level owns the FSM, latency pipeline and write qualification.

Test Plan:
- Position and ROM fill: start at (100,200), ROM all 5'h03.
  - Required: exactly 1400 fb_we pulses.
  - First write at fb_addr=128100, last at 159487, fb_data=3 throughout.
  - done high exactly at cycle 1402, one cycle wide.
- Transparency: ROM even addresses=0, odd=5'h07, start at (0,0).
  - Required: 700 writes, all fb_data=7, first fb_addr=1, no write to fb_addr 0.
- Clipping: start at (620,470), ROM all 5'h01.
  - Required: 200 writes (cols 0..19, rows 0..9).
  - No fb_addr at or above 307200; none with x>=640.
- Handshake: start held high continuously from (10,10).
  - Required: second draw accepted only after the done cycle.
  - start pulses in cycles 5..1402 have no effect; busy is never high during done.
- Reset mid-draw: Reset at cycle 500.
  - Required: fb_we=0, busy=0 from the next cycle.
  - A fresh start at (0,0) then completes 1400 writes normally.
- HFLIP (macro defined): hflip=1, ROM address 0 = 5'h1F, others 5'h02, start at (0,0).
  - Required: fb_data=5'h1F only at fb_addr=27.
